l1l2_bus_arbiter: RTL

- Synchronous controller that shares the single L1↔L2 bus (address, write-enable, 64-bit bidirectional data, active-low completion strobe from L2) between two L1 requesters: port 0 = L1 data cache, port 1 = L1 instruction cache.
- Arbitrates round-robin, drives the bus address/control/write data and its tristate enable, and waits for the L2 strobe handshake.
- Returns read data and a per-port completion pulse.
- Sits between both L1 controllers and the top-level tristate buffer on the L2 bus.

---
 rtl/l1l2_bus_pkg.sv | 16 +
 rtl/l1l2_rr_pick.sv | 23 ++
 rtl/l1l2_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/l1l2_bus_pkg.sv
// rtl/l1l2_bus_pkg.sv - shared state type, widths and port indices for the L1/L2 bus arbiter
package l1l2_bus_pkg;

  localparam int L1L2_ADDR_W = 32;
  localparam int L1L2_DATA_W = 64;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } l1l2_state_e;

endpackage

// File: rtl/l1l2_rr_pick.sv
// rtl/l1l2_rr_pick.sv - 2-way combinational round-robin picker
module l1l2_rr_pick
  import l1l2_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       winner,
  output logic       valid
);

  // rr_ptr only matters when both ports compete
  always_comb begin
    valid = |req;
    if (req[PORT_D] && req[PORT_I]) begin
      winner = rr_ptr;
    end else if (req[PORT_I]) begin
      winner = PORT_I;
    end else begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/l1l2_bus_arbiter.sv
// rtl/l1l2_bus_arbiter.sv - round-robin owner of the shared L1/L2 bus
// Optional transfer timeout: L1L2_BUS_TIMEOUT_EN
module l1l2_bus_arbiter
  import l1l2_bus_pkg::*;
#(
  parameter int ADDR_W         = L1L2_ADDR_W,
  parameter int DATA_W         = L1L2_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we_n,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wdata_oe,
  output logic              bus_req,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_stb_n
);

  l1l2_state_e state;
  logic        rr_ptr;
  logic        owner;
  logic        pick_winner;
  logic        pick_valid;
  logic        timeout_hit;

  l1l2_rr_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

`ifdef L1L2_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic [1:0]       err_q;

  // A strobe in the final cycle wins over the timeout
  assign timeout_hit = (state == XFER) && bus_stb_n && (to_cnt == CNT_LAST);
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= '0;
    end else begin
      err_q <= '0;
      if (state != XFER) begin
        to_cnt <= '0;
      end else if (!timeout_hit) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        err_q[owner] <= 1'b1;
      end
    end
  end
`else
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign err         = 2'b00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= PORT_D;
      owner        <= PORT_D;
      gnt          <= '0;
      done         <= '0;
      rdata        <= '0;
      bus_addr     <= '0;
      bus_we_n     <= 1'b1;
      bus_wdata    <= '0;
      bus_wdata_oe <= 1'b0;
      bus_req      <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner        <= pick_winner;
            rr_ptr       <= ~pick_winner;
            gnt          <= pick_winner ? 2'b10 : 2'b01;
            bus_addr     <= pick_winner ? req_addr1 : req_addr0;
            bus_wdata    <= pick_winner ? req_wdata1 : req_wdata0;
            bus_we_n     <= ~req_we[pick_winner];
            bus_wdata_oe <= req_we[pick_winner];
            bus_req      <= 1'b1;
            state        <= XFER;
          end
        end
        XFER: begin
          if (!bus_stb_n) begin
            if (bus_we_n) begin
              rdata <= bus_rdata;
            end
            done[owner]  <= 1'b1;
            bus_req      <= 1'b0;
            bus_wdata_oe <= 1'b0;
            bus_we_n     <= 1'b1;
            state        <= RELEASE;
          end else if (timeout_hit) begin
            bus_req      <= 1'b0;
            bus_wdata_oe <= 1'b0;
            bus_we_n     <= 1'b1;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          // Holding gnt until the strobe rises keeps one transfer outstanding
          if (bus_stb_n) begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
